memory_port_arbiter: RTL and testbench

Shares the single memory port between the instruction-fetch path and the load/store data path.
Each requester gets its own request/acknowledge handshake. Grants follow fixed priority, with data ahead of fetch. Each transaction is tracked by a three-state FSM and guarded by a timeout counter.
Sits between the CPU datapath (PC/fetch logic and load/store unit) and the memory/bus adapter.

---
 rtl/memory_port_arbiter.sv | 137 +++++++++++++
 tb/tb_memory_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, data first.
// Each transaction is tracked by a small FSM with a timeout guard.
module memory_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int MASK_WIDTH     = XLEN / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Fetch_Req,
  input  logic [XLEN-1:0]       i_Fetch_Addr,
  output logic                  o_Fetch_Ack,
  output logic [XLEN-1:0]       o_Fetch_Data,
  output logic                  o_Fetch_Err,
  input  logic                  i_Data_Req,
  input  logic [XLEN-1:0]       i_Data_Addr,
  input  logic                  i_Data_Write_Enable,
  input  logic [XLEN-1:0]       i_Data_Write_Data,
  input  logic [MASK_WIDTH-1:0] i_Data_Byte_Mask,
  output logic                  o_Data_Ack,
  output logic [XLEN-1:0]       o_Data_Read_Data,
  output logic                  o_Data_Err,
  output logic                  o_Mem_Req,
  output logic [XLEN-1:0]       o_Mem_Addr,
  output logic                  o_Mem_Write_Enable,
  output logic [XLEN-1:0]       o_Mem_Write_Data,
  output logic [MASK_WIDTH-1:0] o_Mem_Byte_Mask,
  input  logic                  i_Mem_Ack,
  input  logic [XLEN-1:0]       i_Mem_Read_Data,
  output logic                  o_Busy
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, S_FETCH, S_DATA} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  fetch_ack_q, fetch_err_q, data_ack_q, data_err_q;
  logic [XLEN-1:0]       fetch_data_q, data_rdata_q;
  logic                  mem_req_q, mem_we_q;
  logic [XLEN-1:0]       mem_addr_q, mem_wdata_q;
  logic [MASK_WIDTH-1:0] mem_mask_q;

  // A requester still holds Req during its own Ack/Err cycle, so it must not be re-granted then.
  logic data_grant, fetch_grant;
  assign data_grant  = i_Data_Req && !(data_ack_q || data_err_q);
  assign fetch_grant = !data_grant && i_Fetch_Req && !(fetch_ack_q || fetch_err_q);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fetch_ack_q  <= 1'b0;
      fetch_err_q  <= 1'b0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mask_q   <= '0;
    end else begin
      fetch_ack_q <= 1'b0;
      fetch_err_q <= 1'b0;
      data_ack_q  <= 1'b0;
      data_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_grant) begin
            state_q     <= S_DATA;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= i_Data_Addr;
            mem_we_q    <= i_Data_Write_Enable;
            mem_wdata_q <= i_Data_Write_Data;
            mem_mask_q  <= i_Data_Byte_Mask;
          end else if (fetch_grant) begin
            if (i_Fetch_Addr[1:0] != 2'b00) begin
              fetch_err_q <= 1'b1;
            end else begin
              state_q     <= S_FETCH;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= i_Fetch_Addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              mem_mask_q  <= '1;
            end
          end
        end
        S_FETCH, S_DATA: begin
          // Ack takes precedence over a timeout landing on the same edge.
          if (i_Mem_Ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (state_q == S_FETCH) begin
              fetch_data_q <= i_Mem_Read_Data;
              fetch_ack_q  <= 1'b1;
            end else begin
              data_rdata_q <= i_Mem_Read_Data;
              data_ack_q   <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (state_q == S_FETCH) fetch_err_q <= 1'b1;
            else                    data_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Fetch_Ack        = fetch_ack_q;
  assign o_Fetch_Err        = fetch_err_q;
  assign o_Fetch_Data       = fetch_data_q;
  assign o_Data_Ack         = data_ack_q;
  assign o_Data_Err         = data_err_q;
  assign o_Data_Read_Data   = data_rdata_q;
  assign o_Mem_Req          = mem_req_q;
  assign o_Mem_Addr         = mem_addr_q;
  assign o_Mem_Write_Enable = mem_we_q;
  assign o_Mem_Write_Data   = mem_wdata_q;
  assign o_Mem_Byte_Mask    = mem_mask_q;
  assign o_Busy             = (state_q != IDLE);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed scenario bench for memory_port_arbiter; timeout shortened to 8 cycles.
module tb_memory_port_arbiter;

  localparam int XLEN = 32;
  localparam int MW   = 4;

  logic            clk;
  logic            rst;
  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_ack, fetch_err;
  logic [XLEN-1:0] fetch_data;
  logic            data_req, data_we;
  logic [XLEN-1:0] data_addr, data_wdata, data_rdata;
  logic [MW-1:0]   data_mask;
  logic            data_ack, data_err;
  logic            mem_req, mem_we, mem_ack;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [MW-1:0]   mem_mask;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  memory_port_arbiter #(.XLEN(XLEN), .MASK_WIDTH(MW), .TIMEOUT_CYCLES(8)) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Fetch_Req(fetch_req), .i_Fetch_Addr(fetch_addr),
    .o_Fetch_Ack(fetch_ack), .o_Fetch_Data(fetch_data), .o_Fetch_Err(fetch_err),
    .i_Data_Req(data_req), .i_Data_Addr(data_addr), .i_Data_Write_Enable(data_we),
    .i_Data_Write_Data(data_wdata), .i_Data_Byte_Mask(data_mask),
    .o_Data_Ack(data_ack), .o_Data_Read_Data(data_rdata), .o_Data_Err(data_err),
    .o_Mem_Req(mem_req), .o_Mem_Addr(mem_addr), .o_Mem_Write_Enable(mem_we),
    .o_Mem_Write_Data(mem_wdata), .o_Mem_Byte_Mask(mem_mask),
    .i_Mem_Ack(mem_ack), .i_Mem_Read_Data(mem_rdata), .o_Busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (mem_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask got %h want 0", mem_mask); end
    n_checks++; if ({fetch_ack, fetch_err, data_ack, data_err} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0000", {fetch_ack, fetch_err, data_ack, data_err}); end
    n_checks++; if ({fetch_data, data_rdata, mem_addr, mem_wdata} !== 128'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {fetch_data, data_rdata, mem_addr, mem_wdata}); end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_fetch;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0040;
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_req got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL fetch_addr got %h want 00000040", mem_addr); end
    n_checks++; if (mem_mask !== 4'hF || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mask_we got %h/%b want f/0", mem_mask, mem_we); end
    n_checks++; if (fetch_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_early_ack got %b want 0", fetch_ack); end
    mem_ack = 1'b1; mem_rdata = 32'h0010_0093;
    tick();
    n_checks++; if (fetch_ack !== 1'b1) begin n_fail++; $display("FAIL fetch_ack got %b want 1", fetch_ack); end
    n_checks++; if (fetch_data !== 32'h0010_0093) begin n_fail++; $display("FAIL fetch_data got %h want 00100093", fetch_data); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_drop got %b want 0", mem_req); end
    mem_ack = 1'b0; fetch_req = 1'b0;
    tick();
    n_checks++; if (fetch_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_after got ack=%b req=%b want 0/0", fetch_ack, mem_req); end
    $display("txn fetch addr=00000040 data=%h", fetch_data);
  endtask

  task automatic test_priority;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0044;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_1000;
    data_wdata = 32'hDEAD_BEEF; data_mask = 4'b0011;
    tick();
    n_checks++; if (mem_addr !== 32'h1000 || mem_we !== 1'b1) begin n_fail++; $display("FAIL prio_store_grant got addr=%h we=%b want 00001000/1", mem_addr, mem_we); end
    n_checks++; if (mem_mask !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_store_data got mask=%h wd=%h want 3/deadbeef", mem_mask, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    n_checks++; if (data_ack !== 1'b1 || fetch_ack !== 1'b0) begin n_fail++; $display("FAIL prio_data_ack got d=%b f=%b want 1/0", data_ack, fetch_ack); end
    mem_ack = 1'b0; // data_req held through its Ack cycle on purpose
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0) begin n_fail++; $display("FAIL prio_fetch_grant got req=%b addr=%h we=%b want 1/00000044/0", mem_req, mem_addr, mem_we); end
    n_checks++; if (mem_mask !== 4'hF) begin n_fail++; $display("FAIL prio_fetch_mask got %h want f", mem_mask); end
    data_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    n_checks++; if (fetch_ack !== 1'b1 || fetch_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL prio_fetch_ack got ack=%b data=%h want 1/cafef00d", fetch_ack, fetch_data); end
    mem_ack = 1'b0; fetch_req = 1'b0;
    tick();
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || data_ack !== 1'b0) begin n_fail++; $display("FAIL prio_no_dup got req=%b busy=%b dack=%b want 0/0/0", mem_req, busy, data_ack); end
    $display("txn store+fetch store=deadbeef fetch=%h", fetch_data);
  endtask

  task automatic test_load_wait;
    int busy_cycles;
    busy_cycles = 0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_2000; data_mask = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      n_checks++; if (mem_req !== 1'b1 || data_ack !== 1'b0) begin n_fail++; $display("FAIL load_wait%0d got req=%b ack=%b want 1/0", k, mem_req, data_ack); end
    end
    tick();
    if (busy === 1'b1) busy_cycles++;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    if (busy === 1'b1) busy_cycles++;
    n_checks++; if (data_ack !== 1'b1) begin n_fail++; $display("FAIL load_ack got %b want 1", data_ack); end
    n_checks++; if (data_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL load_data got %h want 12345678", data_rdata); end
    n_checks++; if (busy_cycles !== 6) begin n_fail++; $display("FAIL load_busy_cycles got %0d want 6", busy_cycles); end
    n_checks++; if (fetch_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL load_fetch_hold got %h want cafef00d", fetch_data); end
    mem_ack = 1'b0; data_req = 1'b0;
    tick();
    $display("txn load addr=00002000 data=%h busy=%0d", data_rdata, busy_cycles);
  endtask

  task automatic test_timeout;
    int req_cycles;
    req_cycles = 0;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_3000; data_wdata = 32'h5555_AAAA;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (mem_req === 1'b1) req_cycles++;
      n_checks++; if (data_err !== 1'b0 || data_ack !== 1'b0) begin n_fail++; $display("FAIL timeout_early%0d got err=%b ack=%b want 0/0", k, data_err, data_ack); end
    end
    tick();
    n_checks++; if (req_cycles !== 8) begin n_fail++; $display("FAIL timeout_req_cycles got %0d want 8", req_cycles); end
    n_checks++; if (data_err !== 1'b1 || data_ack !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_err got err=%b ack=%b req=%b want 1/0/0", data_err, data_ack, mem_req); end
    n_checks++; if (data_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL timeout_rdata_hold got %h want 12345678", data_rdata); end
    data_req = 1'b0;
    tick();
    n_checks++; if (data_err !== 1'b0) begin n_fail++; $display("FAIL timeout_single_pulse got %b want 0", data_err); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick();
    n_checks++; if (data_ack !== 1'b0 || busy !== 1'b0 || data_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL timeout_late_ack got ack=%b busy=%b rd=%h want 0/0/12345678", data_ack, busy, data_rdata); end
    mem_ack = 1'b0;
    tick();
    $display("txn store timeout addr=00003000 req_cycles=%0d", req_cycles);
  endtask

  task automatic test_misaligned;
    fetch_req = 1'b1; fetch_addr = 32'h0000_0042;
    tick();
    n_checks++; if (fetch_err !== 1'b1 || fetch_ack !== 1'b0) begin n_fail++; $display("FAIL misalign_err got err=%b ack=%b want 1/0", fetch_err, fetch_ack); end
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL misalign_no_req got req=%b busy=%b want 0/0", mem_req, busy); end
    tick();
    n_checks++; if (fetch_err !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_masked got err=%b req=%b want 0/0", fetch_err, mem_req); end
    fetch_req = 1'b0;
    tick();
    $display("txn fetch misaligned addr=00000042");
  endtask

  task automatic test_reset_mid_load;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_4000; data_mask = 4'hF;
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant got %b want 1", mem_req); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; data_req = 1'b0;
    n_checks++; if ({mem_req, busy, mem_we, data_ack, data_err, fetch_ack, fetch_err} !== 7'b0) begin n_fail++; $display("FAIL rstmid_ctrl got %b want 0000000", {mem_req, busy, mem_we, data_ack, data_err, fetch_ack, fetch_err}); end
    n_checks++; if ({mem_addr, mem_mask, fetch_data, data_rdata} !== 100'h0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", {mem_addr, mem_mask, fetch_data, data_rdata}); end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    n_checks++; if (data_ack !== 1'b0 || busy !== 1'b0 || data_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_late_ack got ack=%b busy=%b rd=%h want 0/0/0", data_ack, busy, data_rdata); end
    mem_ack = 1'b0;
    tick();
    $display("txn load reset mid-transaction addr=00004000");
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_mask = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_load_wait();
    test_timeout();
    test_misaligned();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
